// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Pipelined add/subtract built from 4-bit carry-lookahead groups. Stage k
//   resolves nibble k using the carry registered by stage k-1, so a result
//   emerges GROUPS cycles after acceptance, one per cycle when unstalled.
//   A valid/ready handshake on both sides; a stalled output freezes the
//   whole pipeline.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set valid          in_ready   operand set accepted
//   a, b       operands (WIDTH)           cin        carry-in / borrow-in
//   sub        0 = a+b+cin, 1 = a-b-cin
//   out_valid  result valid               out_ready  result consumed
//   sum        result modulo 2^WIDTH
//   cout       add: carry-out; sub: 1 = no borrow
//   ovf        two's-complement overflow
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GROUPS = WIDTH / 4;

  logic             stall;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction as a + ~b + ~cin: borrow-in becomes an inverted carry-in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign take     = in_valid & in_ready;

  // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g, p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, p ^ {c3, c2, c1, ci}};
  endfunction

  for (genvar k = 0; k < GROUPS; k++) begin : g_stage
    // Operand bits still unresolved on entry to stage k.
    localparam int RW = WIDTH - 4 * k;

    logic [RW-1:0]    op_a;
    logic [RW-1:0]    op_b;
    logic             c_in;
    logic             vin;
    logic [4*k+3:0]   s_next;
    logic [4:0]       r;
    logic             v;
    logic             co;
    logic [4*k+3:0]   s;

    if (k == 0) begin : g_src
      assign op_a   = a;
      assign op_b   = b_eff;
      assign c_in   = cin_eff;
      assign vin    = take;
      assign s_next = r[3:0];
    end else begin : g_src
      assign op_a   = g_stage[k-1].g_rem.ra;
      assign op_b   = g_stage[k-1].g_rem.rb;
      assign c_in   = g_stage[k-1].co;
      assign vin    = g_stage[k-1].v;
      assign s_next = {r[3:0], g_stage[k-1].s};
    end

    assign r = cla4(op_a[3:0], op_b[3:0], c_in);

    always_ff @(posedge clk) begin
      if (rst) begin
        v  <= 1'b0;
        co <= 1'b0;
        s  <= '0;
      end else if (!stall) begin
        v  <= vin;
        co <= r[4];
        s  <= s_next;
      end
    end

    if (k < GROUPS - 1) begin : g_rem
      logic [RW-5:0] ra;
      logic [RW-5:0] rb;
      always_ff @(posedge clk) begin
        if (rst) begin
          ra <= '0;
          rb <= '0;
        end else if (!stall) begin
          ra <= op_a[RW-1:4];
          rb <= op_b[RW-1:4];
        end
      end
    end else begin : g_last
      logic ov;
      // Carry into the MSB is recovered as sum[3] ^ p[3], so overflow is
      // sum[3] ^ a[3] ^ b_eff[3] ^ carry_out without exporting c3.
      always_ff @(posedge clk) begin
        if (rst) begin
          ov <= 1'b0;
        end else if (!stall) begin
          ov <= r[3] ^ op_a[3] ^ op_b[3] ^ r[4];
        end
      end
    end
  end

  assign out_valid = g_stage[GROUPS-1].v;
  assign sum       = g_stage[GROUPS-1].s;
  assign cout      = g_stage[GROUPS-1].co;
  assign ovf       = g_stage[GROUPS-1].g_last.ov;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Testbench for pipelined_cla_addsub (WIDTH=16): directed corner cases plus
// random streaming against a cycle-level reference model of a GROUPS-deep
// result delay line that freezes while the output is stalled.
module tb_pipelined_cla_addsub;

  localparam int WIDTH  = 16;
  localparam int GROUPS = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference delay line: valid flag and {ovf, cout, sum} per slot.
  logic        mv[GROUPS];
  logic [17:0] mr[GROUPS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic s);
    logic [16:0] full;
    logic        ov;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      ov   = (x[15] == y[15]) && (full[15] != x[15]);
    end else begin
      full = {1'b0, x} + {1'b0, ~y} + {16'd0, ~ci};
      ov   = (x[15] != y[15]) && (full[15] != x[15]);
    end
    return {ov, full};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < GROUPS; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
  endtask

  // One clock cycle: compare outputs against the model, then step the model
  // across the rising edge. Called with inputs already set just after negedge.
  task automatic tick(output logic acc);
    logic exp_ready;
    #1;
    exp_ready = !rst && !(mv[GROUPS-1] && !out_ready);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(mv[GROUPS-1]));
    if (mv[GROUPS-1]) check("result", 32'({ovf, cout, sum}), 32'(mr[GROUPS-1]));
    acc = in_valid && exp_ready;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else if (exp_ready) begin
      for (int i = GROUPS - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = acc;
      mr[0] = acc ? ref_op(a, b, cin, sub) : 18'd0;
    end
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s, input logic [15:0] es,
                         input logic ec, input logic eo);
    logic acc;
    int   lat;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s; out_ready = 1'b1;
    tick(acc);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    // Changes after acceptance must not affect the result.
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick(acc);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(GROUPS));
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick(acc);
  endtask

  task automatic rand_inputs();
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  initial begin
    logic acc;
    int   n_acc;
    int   n_stall;
    int   guard;
    logic [7:0] obs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);

    // Reset behaviour, with in_valid raised during reset.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    tick(acc);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0; in_valid = 1'b0;

    // Directed corners.
    run_one("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("signed_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("borrow",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1);

    // Streaming: 8 back-to-back ops, output stalled for 3 cycles mid-stream.
    n_acc = 0; n_stall = 0; guard = 0;
    while (n_acc < 8 && guard < 40) begin
      in_valid  = 1'b1;
      out_ready = !(guard >= 5 && guard <= 7);
      #1;
      if (!in_ready) n_stall++;
      #0;
      tick(acc);
      if (acc) begin
        n_acc++;
        rand_inputs();
      end
      guard++;
    end
    check("stream_accepted", 32'(n_acc), 32'd8);
    check("stream_stall_cycles", 32'(n_stall), 32'd3);
    check("stream_cycles", 32'(guard), 32'd11);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (GROUPS + 2) tick(acc);

    // Reset mid-operation discards in-flight work.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rand_inputs();
      tick(acc);
    end
    rst = 1'b1; in_valid = 1'b1;
    tick(acc);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    run_one("after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Bubbles propagate unchanged.
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4) && (i % 2 == 0);
      rand_inputs();
      obs[i] = out_valid;
      tick(acc);
    end
    check("bubble_pattern", 32'(obs), 32'h50);

    // Random traffic with random backpressure and one reset.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = (i == 200);
      rand_inputs();
      tick(acc);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (GROUPS + 2) tick(acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
